// File: rtl/core_run_ctrl.sv
// Run sequencer and data-memory arbiter for the 9-bit-ISA core.
// Define RUN_TIMEOUT_EN to enable the RUN watchdog (MAX_CYCLES); otherwise timeout is tied low.
module core_run_ctrl #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8,
  parameter int PC_W         = 12,
  parameter int START_CYCLES = 2,
  parameter int MAX_CYCLES   = 4096,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              host_go,
  input  logic [PC_W-1:0]   host_prog_base,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              core_start,
  output logic              core_pc_load,
  output logic [PC_W-1:0]   core_pc_init,
  input  logic              core_done,
  input  logic              core_mem_we,
  input  logic [ADDR_W-1:0] core_mem_addr,
  input  logic [DATA_W-1:0] core_mem_wdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              run_done,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycle_count
);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN, S_DONE} state_e;

  localparam int LCW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
  localparam logic [LCW-1:0]   LAUNCH_LAST = LCW'(START_CYCLES - 1);
  localparam logic [CNT_W-1:0] WD_LAST     = CNT_W'(MAX_CYCLES - 1);

`ifdef RUN_TIMEOUT_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  state_e            state_q, state_d;
  logic [LCW-1:0]    launch_cnt_q, launch_cnt_d;
  logic [PC_W-1:0]   pc_init_q, pc_init_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              timeout_q, timeout_d;
  logic              host_ack_q;
  logic [DATA_W-1:0] host_rdata_q;

  logic host_owns;
  logic host_accept;
  logic cnt_full;
  logic wd_hit;

  assign host_owns   = (state_q == S_IDLE) || (state_q == S_DONE);
  assign host_accept = host_owns && host_req;
  assign cnt_full    = &cnt_q;
  assign wd_hit      = WD_EN && (cnt_q == WD_LAST);

  always_comb begin
    state_d      = state_q;
    launch_cnt_d = launch_cnt_q;
    pc_init_d    = pc_init_q;
    cnt_d        = cnt_q;
    timeout_d    = timeout_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (host_go) begin
          pc_init_d    = host_prog_base;
          cnt_d        = '0;
          timeout_d    = 1'b0;
          launch_cnt_d = '0;
          state_d      = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        // core_done may still be high from the previous run; it is not looked at here.
        if (launch_cnt_q == LAUNCH_LAST) state_d = S_RUN;
        else launch_cnt_d = launch_cnt_q + LCW'(1);
      end
      S_RUN: begin
        if (core_done) begin
          state_d = S_DONE;
          if (!cnt_full) cnt_d = cnt_q + CNT_W'(1);
        end else if (wd_hit) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end else if (!cnt_full) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      launch_cnt_q <= '0;
      pc_init_q    <= '0;
      cnt_q        <= '0;
      timeout_q    <= 1'b0;
      host_ack_q   <= 1'b0;
      host_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      launch_cnt_q <= launch_cnt_d;
      pc_init_q    <= pc_init_d;
      cnt_q        <= cnt_d;
      timeout_q    <= timeout_d;
      host_ack_q   <= host_accept;
      if (host_accept) host_rdata_q <= host_we ? host_wdata : mem_rdata;
    end
  end

  // Memory port mux: the core only ever reaches dat_mem while in RUN.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = core_mem_addr;
    mem_wdata = core_mem_wdata;
    if (state_q == S_RUN) begin
      mem_we = core_mem_we;
    end else if (host_owns) begin
      mem_we    = host_req && host_we && !reset;
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
    end
  end

  assign core_start   = (state_q != S_RUN);
  assign core_pc_load = (state_q == S_LAUNCH) && (launch_cnt_q == '0);
  assign core_pc_init = pc_init_q;
  assign busy         = (state_q == S_LAUNCH) || (state_q == S_RUN);
  assign run_done     = (state_q == S_DONE);
  assign timeout      = timeout_q;
  assign cycle_count  = cnt_q;
  assign host_ack     = host_ack_q;
  assign host_rdata   = host_rdata_q;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Self-checking bench for core_run_ctrl: host access scoreboard plus launch/run/done sequencing.
module tb_core_run_ctrl;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int PC_W   = 12;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              host_go;
  logic [PC_W-1:0]   host_prog_base;
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_ack;
  logic [DATA_W-1:0] host_rdata;
  logic              core_start;
  logic              core_pc_load;
  logic [PC_W-1:0]   core_pc_init;
  logic              core_done;
  logic              core_mem_we;
  logic [ADDR_W-1:0] core_mem_addr;
  logic [DATA_W-1:0] core_mem_wdata;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  logic              run_done;
  logic              timeout;
  logic [CNT_W-1:0]  cycle_count;

  core_run_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .PC_W(PC_W),
    .START_CYCLES(2), .MAX_CYCLES(16), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .host_go(host_go), .host_prog_base(host_prog_base),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata),
    .core_start(core_start), .core_pc_load(core_pc_load), .core_pc_init(core_pc_init),
    .core_done(core_done), .core_mem_we(core_mem_we), .core_mem_addr(core_mem_addr),
    .core_mem_wdata(core_mem_wdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .run_done(run_done), .timeout(timeout), .cycle_count(cycle_count)
  );

  // ---------------- clock / memory ----------------
  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem [256];
  int                we_cnt = 0;
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      we_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog sim_time got=expired exp=finish");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int                n_checks = 0;
  int                n_fail   = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] exp_v;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && host_ack) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ack", 32'd1, 32'd0);
      end else begin
        exp_v = exp_q.pop_front();
        check("host_rdata", host_rdata, exp_v);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    host_go = 1'b0; host_req = 1'b0; host_we = 1'b0;
    core_done = 1'b0; core_mem_we = 1'b0;
  endtask

  // One host access cycle; when accepted, the expected readback is queued.
  task automatic host_op(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                         input logic accepted, input logic [7:0] exp);
    host_req = 1'b1; host_we = we; host_addr = addr; host_wdata = wdata;
    if (accepted) exp_q.push_back(we ? wdata : exp);
    tick();
    host_req = 1'b0; host_we = 1'b0;
  endtask

  task automatic go(input logic [11:0] base);
    host_go = 1'b1; host_prog_base = base;
    tick();
    host_go = 1'b0;
  endtask

  int we_base;
  int n_run;
  int guard;

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
    reset = 1'b1; idle_inputs();
    host_prog_base = '0; host_addr = 8'h10; host_wdata = 8'h77;
    core_mem_addr = '0; core_mem_wdata = '0;
    host_req = 1'b1; host_we = 1'b1;
    @(negedge clk);
    check("rst_core_start", core_start, 1);
    check("rst_busy", busy, 0);
    check("rst_run_done", run_done, 0);
    check("rst_timeout", timeout, 0);
    check("rst_cycle_count", cycle_count, 0);
    check("rst_host_ack", host_ack, 0);
    check("rst_host_rdata", host_rdata, 0);
    check("rst_pc_load", core_pc_load, 0);
    check("rst_pc_init", core_pc_init, 0);
    check("rst_mem_we", mem_we, 0);
    host_req = 1'b0; host_we = 1'b0;
    @(posedge clk); #1 reset = 1'b0;

    // Host write then back-to-back read in IDLE.
    we_base = we_cnt;
    host_op(1'b1, 8'h10, 8'hA5, 1'b1, 8'h00);
    host_op(1'b0, 8'h10, 8'h00, 1'b1, 8'hA5);
    tick();
    check("host_wr_pulses", we_cnt - we_base, 1);
    check("mem_10_written", mem[8'h10], 8'hA5);

    // Launch at 0x040 with a stale core_done held through LAUNCH.
    go(12'h040);
    core_done = 1'b1;
    @(negedge clk);
    check("l1_pc_load", core_pc_load, 1);
    check("l1_pc_init", core_pc_init, 12'h040);
    check("l1_core_start", core_start, 1);
    check("l1_busy", busy, 1);
    tick();
    @(negedge clk);
    check("l2_pc_load", core_pc_load, 0);
    check("l2_core_start", core_start, 1);
    tick();
    core_done = 1'b0;

    // RUN: core write, blocked host accesses, ignored host_go, done on RUN cycle 10.
    we_base = we_cnt;
    for (int i = 1; i <= 10; i++) begin
      idle_inputs();
      if (i == 1) begin
        core_mem_we = 1'b1; core_mem_addr = 8'h20; core_mem_wdata = 8'h3C;
      end
      if (i == 2) begin
        host_req = 1'b1; host_we = 1'b1; host_addr = 8'h10; host_wdata = 8'h11;
      end
      if (i == 3) begin
        host_go = 1'b1; host_prog_base = 12'h123; host_req = 1'b1; host_addr = 8'h20;
      end
      if (i == 10) core_done = 1'b1;
      @(negedge clk);
      if (i == 5) begin
        check("run_core_start", core_start, 0);
        check("run_busy", busy, 1);
        check("run_count_mid", cycle_count, 4);
      end
      tick();
    end
    idle_inputs();
    @(negedge clk);
    check("done_run_done", run_done, 1);
    check("done_cycle_count", cycle_count, 10);
    check("done_core_start", core_start, 1);
    check("done_busy", busy, 0);
    check("done_pc_init_kept", core_pc_init, 12'h040);
    check("done_timeout", timeout, 0);
    check("run_mem_writes", we_cnt - we_base, 1);

    // Core write attempt in DONE is blocked; host reads show core data and untouched host data.
    core_mem_we = 1'b1; core_mem_addr = 8'h20; core_mem_wdata = 8'h99;
    tick();
    core_mem_we = 1'b0;
    host_op(1'b0, 8'h20, 8'h00, 1'b1, 8'h3C);
    host_op(1'b0, 8'h10, 8'h00, 1'b1, 8'hA5);
    tick();

    // Long run with core_done held low.
    go(12'h080);
`ifdef RUN_TIMEOUT_EN
    n_run = 0; guard = 0;
    while (!run_done && guard < 60) begin
      @(negedge clk);
      if (!run_done && !core_start) n_run++;
      guard++;
    end
    check("wd_in_budget", guard < 60, 1);
    check("wd_run_cycles", n_run, 16);
    check("wd_timeout", timeout, 1);
    check("wd_cycle_count", cycle_count, 15);
    tick();
    go(12'h081);
    @(negedge clk);
    check("wd_timeout_cleared", timeout, 0);
    guard = 0;
    while (!run_done && guard < 60) begin
      tick();
      guard++;
    end
    check("wd2_in_budget", guard < 60, 1);
`else
    repeat (22) tick();
    core_done = 1'b1;
    @(negedge clk);
    check("nowd_still_busy", busy, 1);
    check("nowd_timeout", timeout, 0);
    check("nowd_count", cycle_count, 20);
    tick();
    core_done = 1'b0;
    @(negedge clk);
    check("nowd_done", run_done, 1);
    check("nowd_count_final", cycle_count, 21);
`endif

    // Asynchronous reset in the middle of a run.
    tick();
    go(12'h0F0);
    repeat (5) tick();
    @(negedge clk);
    check("pre_rst_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    check("arst_core_start", core_start, 1);
    check("arst_busy", busy, 0);
    check("arst_cycle_count", cycle_count, 0);
    check("arst_pc_init", core_pc_init, 0);
    check("arst_run_done", run_done, 0);
    @(posedge clk); #1 reset = 1'b0;

    // host_go and a host read in the same IDLE cycle: both take effect.
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h20;
    exp_q.push_back(8'h3C);
    go(12'h0AA);
    host_req = 1'b0;
    @(negedge clk);
    check("relaunch_pc_load", core_pc_load, 1);
    check("relaunch_pc_init", core_pc_init, 12'h0AA);
    check("relaunch_busy", busy, 1);
    tick();
    tick();
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    @(negedge clk);
    check("relaunch_done", run_done, 1);
    check("relaunch_count", cycle_count, 1);

    repeat (2) tick();
    check("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/core_run_ctrl.md
Name: core_run_ctrl

Overview:
- Run sequencer and data-memory arbiter for the 9-bit-ISA core.
- Shares the single dat_mem port between a host loader/readback port and the core.
- Launches the core at a host-chosen start PC, holds it through start, and detects done or a watchdog timeout.
- Sits between the test/host harness and the core top; owns the core start line and the dat_mem write/address/data muxing.

Parameters:
ADDR_W, 8, data memory address width
DATA_W, 8, data memory word width
PC_W, 12, program counter width
START_CYCLES, 2, cycles core_start is held high in LAUNCH (>=1)
MAX_CYCLES, 4096, RUN watchdog limit in cycles (only with RUN_TIMEOUT_EN)
CNT_W, 16, cycle counter width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
host_go  in  1  launch request, sampled when idle/done
host_prog_base  in  PC_W  start PC, latched on accepted host_go
host_req  in  1  host memory access valid (one access per high cycle)
host_we  in  1  1=write, 0=read
host_addr  in  ADDR_W  host access address
host_wdata  in  DATA_W  host write data
host_ack  out  1  access completed, one cycle after acceptance
host_rdata  out  DATA_W  read data, valid with host_ack
core_start  out  1  to core start input; high holds core PC
core_pc_load  out  1  one-cycle PC load strobe
core_pc_init  out  PC_W  PC value for core_pc_load
core_done  in  1  core done flag
core_mem_we  in  1  core data-mem write enable
core_mem_addr  in  ADDR_W  core data-mem address
core_mem_wdata  in  DATA_W  core data-mem write data
mem_we  out  1  to dat_mem wen
mem_addr  out  ADDR_W  to dat_mem addr
mem_wdata  out  DATA_W  to dat_mem dat_in
mem_rdata  in  DATA_W  from dat_mem dat_out (combinational read)
busy  out  1  high in LAUNCH and RUN
run_done  out  1  high in DONE
timeout  out  1  last run ended by watchdog
cycle_count  out  CNT_W  RUN cycles of the current/last run

Behaviour:
- States: IDLE, LAUNCH, RUN, DONE.
- Reset (async): state=IDLE, core_start=1, core_pc_load=0, core_pc_init=0, host_ack=0, host_rdata=0, busy=0, run_done=0, timeout=0, cycle_count=0, mem_we=0. Reset in any state aborts the run immediately.
- core_start = 1 in every state except RUN (core frozen while idle, launching or done).
- IDLE/DONE + host_go=1:
  - latch host_prog_base into core_pc_init;
  - clear cycle_count and timeout;
  - go to LAUNCH.
- host_go in LAUNCH/RUN is ignored.
- LAUNCH:
  - core_pc_load=1 in the first LAUNCH cycle only.
  - Stays START_CYCLES cycles, then goes to RUN.
  - core_done is ignored (stale).
- RUN:
  - cycle_count increments each cycle, saturating at all-ones.
  - core_done=1 goes to DONE next edge; the count includes that cycle.
- DONE: run_done=1. Holds until host_go or reset.
- Memory arbitration (combinational mux):
  - In RUN: mem_addr/mem_wdata come from the core; mem_we=core_mem_we.
  - In IDLE/DONE: host owns the port. mem_we=host_req&host_we; mem_addr=host_addr; mem_wdata=host_wdata.
  - In LAUNCH: mem_we=0; mem_addr=core_mem_addr.
- Host accept: host_req=1 in IDLE/DONE is accepted that cycle.
  - At that edge, host_rdata <= mem_rdata (for writes, host_rdata <= host_wdata).
  - host_ack=1 for the following single cycle.
  - Back-to-back accepts give back-to-back acks.
- host_req in LAUNCH/RUN is not accepted: no ack, no memory effect. The host must re-present it later.
- host_go and host_req in the same IDLE cycle: the access is accepted and completes (ack next cycle) and the launch also proceeds.
- Core writes outside RUN are blocked.

Optional Feature:
- RUN_TIMEOUT_EN defined:
  - In RUN, when cycle_count == MAX_CYCLES-1 and core_done=0, go to DONE with timeout=1.
  - If core_done is high in that same cycle, done wins and timeout stays 0.
- Undefined: timeout is tied 0; RUN ends only on core_done or reset.

Test Plan:
- Host writes 0xA5 to addr 0x10, then reads addr 0x10 in IDLE -> mem_we pulses once; host_ack on the cycle after each accept; host_rdata=0xA5.
- host_go with base 0x040, START_CYCLES=2 -> core_pc_load for one cycle with core_pc_init=0x040; core_start high 2 cycles then low; busy=1.
- In RUN, core writes 0x3C to 0x20; core_done asserted after 10 RUN cycles -> DONE, run_done=1, cycle_count=10, core_start=1; host read of 0x20 returns 0x3C.
- host_req during RUN -> host_ack stays 0 and memory is unchanged; host_go during RUN is ignored (core_pc_init unchanged).
- RUN_TIMEOUT_EN, MAX_CYCLES=16, core_done held 0 -> DONE after 16 RUN cycles with timeout=1, cycle_count=15. A second host_go clears timeout.
- Assert reset mid-RUN -> all outputs immediately take reset values (core_start=1, busy=0); the next host_go launches normally.
